// File: rtl/rob_commit.sv
// rob_commit: in-order retirement stage on the consume side of the ROB.
// Each cycle it retires the longest eligible prefix of the EXT_COUNT head
// entries. Stores go out one at a time through a req/ack port. A faulting
// head entry is discarded and produces a one-cycle flush.
// Optional feature: define ROB_COMMIT_STATS_EN to build the retired_count
// counter. Without it, retired_count is tied to zero.

package rob_commit_pkg;
  typedef struct packed {
    logic [4:0]  dest_reg;
    logic        dest_reg_valid;
    logic [31:0] result_lo;
    logic        is_store;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic        exception;
    logic [31:0] pc;
  } rob_entry_t;
endpackage

module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int EXT_COUNT    = 2,
  parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  rob_entry_t              slot_data [EXT_COUNT],
  input  logic                    slot_valid [EXT_COUNT],
  input  logic                    empty,
  output logic                    consume,
  output logic [EXTCOUNTLOG2-1:0] consume_count,
  output logic                    rf_we [EXT_COUNT],
  output logic [4:0]              rf_waddr [EXT_COUNT],
  output logic [31:0]             rf_wdata [EXT_COUNT],
  output logic                    st_req,
  output logic [31:0]             st_addr,
  output logic [31:0]             st_data,
  input  logic                    st_ack,
  output logic                    flush,
  output logic [31:0]             flush_pc,
  output logic [31:0]             retired_count
);

  // Width able to hold the count 0..EXT_COUNT.
  localparam int CNT_W = $clog2(EXT_COUNT + 1);

  typedef enum logic [1:0] {S_RUN, S_ST_WAIT, S_FLUSH} state_t;

  state_t                  state_q, state_d;
  logic                    elig [EXT_COUNT];
  logic                    retire [EXT_COUNT];
  logic [CNT_W-1:0]        n_ret;
  logic                    consume_c;
  logic [EXTCOUNTLOG2-1:0] consume_count_c;

  logic                    rf_we_q [EXT_COUNT];
  logic                    rf_we_d [EXT_COUNT];
  logic [4:0]              rf_waddr_q [EXT_COUNT];
  logic [4:0]              rf_waddr_d [EXT_COUNT];
  logic [31:0]             rf_wdata_q [EXT_COUNT];
  logic [31:0]             rf_wdata_d [EXT_COUNT];
  logic                    st_req_q, st_req_d;
  logic [31:0]             st_addr_q, st_addr_d;
  logic [31:0]             st_data_q, st_data_d;
  logic                    flush_q, flush_d;
  logic [31:0]             flush_pc_q, flush_pc_d;

  // Eligible prefix: an entry qualifies only if every older entry does too.
  always_comb begin
    logic prefix;
    prefix = ~empty;
    n_ret  = '0;
    for (int k = 0; k < EXT_COUNT; k++) begin
      prefix  = prefix & slot_valid[k] & ~slot_data[k].exception & ~slot_data[k].is_store;
      elig[k] = prefix;
      n_ret   = n_ret + CNT_W'(prefix);
    end
  end

  // FSM next state, consume handshake, store and flush capture.
  always_comb begin
    state_d         = state_q;
    consume_c       = 1'b0;
    consume_count_c = '0;
    st_req_d        = st_req_q;
    st_addr_d       = st_addr_q;
    st_data_d       = st_data_q;
    flush_d         = 1'b0;
    flush_pc_d      = flush_pc_q;
    for (int k = 0; k < EXT_COUNT; k++) retire[k] = 1'b0;

    case (state_q)
      S_RUN: begin
        if (n_ret != '0) begin
          consume_c       = 1'b1;
          consume_count_c = EXTCOUNTLOG2'(n_ret - 1'b1);
          for (int k = 0; k < EXT_COUNT; k++) retire[k] = elig[k];
        end else if (~empty && slot_valid[0] && slot_data[0].exception) begin
          // Fault wins over a store flag; the entry is dropped, not retired.
          consume_c  = 1'b1;
          flush_d    = 1'b1;
          flush_pc_d = slot_data[0].pc;
          state_d    = S_FLUSH;
        end else if (~empty && slot_valid[0] && slot_data[0].is_store) begin
          st_req_d  = 1'b1;
          st_addr_d = slot_data[0].store_addr;
          st_data_d = slot_data[0].store_data;
          state_d   = S_ST_WAIT;
        end
      end
      S_ST_WAIT: begin
        if (st_ack) begin
          consume_c = 1'b1;
          st_req_d  = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // RF write set: skip x0, and let the youngest retiring writer of a register win.
  always_comb begin
    for (int k = 0; k < EXT_COUNT; k++) begin
      rf_we_d[k] = retire[k] & slot_data[k].dest_reg_valid & (slot_data[k].dest_reg != 5'd0);
      for (int j = 0; j < EXT_COUNT; j++) begin
        if (j > k && retire[j] && slot_data[j].dest_reg_valid &&
            slot_data[j].dest_reg == slot_data[k].dest_reg)
          rf_we_d[k] = 1'b0;
      end
      rf_waddr_d[k] = rf_we_d[k] ? slot_data[k].dest_reg  : rf_waddr_q[k];
      rf_wdata_d[k] = rf_we_d[k] ? slot_data[k].result_lo : rf_wdata_q[k];
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_RUN;
      st_req_q   <= 1'b0;
      st_addr_q  <= '0;
      st_data_q  <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      for (int k = 0; k < EXT_COUNT; k++) begin
        rf_we_q[k]    <= 1'b0;
        rf_waddr_q[k] <= '0;
        rf_wdata_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      st_req_q   <= st_req_d;
      st_addr_q  <= st_addr_d;
      st_data_q  <= st_data_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
      for (int k = 0; k < EXT_COUNT; k++) begin
        rf_we_q[k]    <= rf_we_d[k];
        rf_waddr_q[k] <= rf_waddr_d[k];
        rf_wdata_q[k] <= rf_wdata_d[k];
      end
    end
  end

  assign consume       = consume_c & reset_n;
  assign consume_count = consume_count_c;
  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign st_req        = st_req_q;
  assign st_addr       = st_addr_q;
  assign st_data       = st_data_q;
  assign flush         = flush_q;
  assign flush_pc      = flush_pc_q;

`ifdef ROB_COMMIT_STATS_EN
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      retired_count_q, retired_count_d;

  // Count RUN retirements and acknowledged stores; dropped faults are not counted.
  always_comb begin
    cnt_inc = '0;
    if (state_q == S_RUN)
      cnt_inc = n_ret;
    else if (state_q == S_ST_WAIT && st_ack)
      cnt_inc = CNT_W'(1);
    retired_count_d = retired_count_q + 32'(cnt_inc);
  end

  // Retired-instruction counter, wraps modulo 2^32.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) retired_count_q <= '0;
    else          retired_count_q <= retired_count_d;
  end

  assign retired_count = retired_count_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Directed testbench for rob_commit (EXT_COUNT = 2).
`timescale 1ns/1ps
module tb_rob_commit;
  import rob_commit_pkg::*;

  localparam int EC = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  rob_entry_t  slot_data [EC];
  logic        slot_valid [EC];
  logic        empty, st_ack;
  logic        consume;
  logic [0:0]  consume_count;
  logic        rf_we [EC];
  logic [4:0]  rf_waddr [EC];
  logic [31:0] rf_wdata [EC];
  logic        st_req;
  logic [31:0] st_addr, st_data;
  logic        flush;
  logic [31:0] flush_pc, retired_count;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_cnt = 0;

  rob_commit #(.EXT_COUNT(EC), .EXTCOUNTLOG2(1)) dut (
    .clock(clock), .reset_n(reset_n), .slot_data(slot_data), .slot_valid(slot_valid),
    .empty(empty), .consume(consume), .consume_count(consume_count),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack),
    .flush(flush), .flush_pc(flush_pc), .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_retired();
`ifdef ROB_COMMIT_STATS_EN
    return exp_cnt;
`else
    return 32'd0;
`endif
  endfunction

  // Inputs change 2ns after a rising edge; combinational outputs are sampled 3ns later.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clr();
    for (int k = 0; k < EC; k++) begin
      slot_data[k]  = '0;
      slot_valid[k] = 1'b0;
    end
    empty  = 1'b1;
    st_ack = 1'b0;
  endtask

  task automatic alu(input int k, input logic [4:0] d, input logic [31:0] v);
    slot_data[k]                = '0;
    slot_data[k].dest_reg       = d;
    slot_data[k].dest_reg_valid = 1'b1;
    slot_data[k].result_lo      = v;
    slot_valid[k]               = 1'b1;
    empty                       = 1'b0;
  endtask

  task automatic store(input int k, input logic [31:0] a, input logic [31:0] d);
    slot_data[k]            = '0;
    slot_data[k].is_store   = 1'b1;
    slot_data[k].store_addr = a;
    slot_data[k].store_data = d;
    slot_valid[k]           = 1'b1;
    empty                   = 1'b0;
  endtask

  task automatic test_reset();
    clr();
    alu(0, 5'd3, 32'h1);
    settle();
    checks++; if (consume !== 1'b0) begin failures++; $display("FAIL reset_consume got=%0b exp=0", consume); end
    checks++; if ({rf_we[1], rf_we[0]} !== 2'b00) begin failures++; $display("FAIL reset_rf_we got=%b exp=00", {rf_we[1], rf_we[0]}); end
    checks++; if ({st_req, flush} !== 2'b00) begin failures++; $display("FAIL reset_req_flush got=%b exp=00", {st_req, flush}); end
    checks++; if ({st_addr, st_data, flush_pc, rf_waddr[0], rf_wdata[0]} !== '0) begin failures++; $display("FAIL reset_data got=%0h exp=0", {st_addr, st_data, flush_pc}); end
    checks++; if (retired_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", retired_count); end
    step(); step();
    clr();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_two_alu();
    clr(); alu(0, 5'd3, 32'hA); alu(1, 5'd4, 32'hB);
    settle();
    checks++; if ({consume, consume_count} !== 2'b11) begin failures++; $display("FAIL two_alu_consume got=%b exp=11", {consume, consume_count}); end
    step(); clr(); exp_cnt += 2;
    checks++; if ({rf_we[1], rf_we[0]} !== 2'b11) begin failures++; $display("FAIL two_alu_we got=%b exp=11", {rf_we[1], rf_we[0]}); end
    checks++; if (rf_waddr[0] !== 5'd3 || rf_waddr[1] !== 5'd4) begin failures++; $display("FAIL two_alu_waddr got=%0d,%0d exp=3,4", rf_waddr[0], rf_waddr[1]); end
    checks++; if (rf_wdata[0] !== 32'hA || rf_wdata[1] !== 32'hB) begin failures++; $display("FAIL two_alu_wdata got=%0h,%0h exp=a,b", rf_wdata[0], rf_wdata[1]); end
    checks++; if (retired_count !== exp_retired()) begin failures++; $display("FAIL two_alu_count got=%0d exp=%0d", retired_count, exp_retired()); end
    step();
    checks++; if ({rf_we[1], rf_we[0]} !== 2'b00) begin failures++; $display("FAIL idle_we got=%b exp=00", {rf_we[1], rf_we[0]}); end
  endtask

  task automatic test_partial();
    clr(); alu(0, 5'd5, 32'h55); alu(1, 5'd6, 32'h66); slot_valid[1] = 1'b0;
    settle();
    checks++; if ({consume, consume_count} !== 2'b10) begin failures++; $display("FAIL partial_consume got=%b exp=10", {consume, consume_count}); end
    step(); clr(); exp_cnt += 1;
    checks++; if ({rf_we[1], rf_we[0]} !== 2'b01 || rf_waddr[0] !== 5'd5) begin failures++; $display("FAIL partial_we got=%b/%0d exp=01/5", {rf_we[1], rf_we[0]}, rf_waddr[0]); end
  endtask

  task automatic test_same_dest();
    clr(); alu(0, 5'd7, 32'h11); alu(1, 5'd7, 32'h22);
    settle();
    checks++; if ({consume, consume_count} !== 2'b11) begin failures++; $display("FAIL same_dest_consume got=%b exp=11", {consume, consume_count}); end
    step(); clr(); exp_cnt += 2;
    checks++; if ({rf_we[1], rf_we[0]} !== 2'b10) begin failures++; $display("FAIL same_dest_we got=%b exp=10", {rf_we[1], rf_we[0]}); end
    checks++; if (rf_waddr[1] !== 5'd7 || rf_wdata[1] !== 32'h22) begin failures++; $display("FAIL same_dest_data got=%0d/%0h exp=7/22", rf_waddr[1], rf_wdata[1]); end
  endtask

  task automatic test_dest_zero();
    clr(); alu(0, 5'd0, 32'h12); alu(1, 5'd8, 32'h34); slot_data[1].dest_reg_valid = 1'b0;
    settle();
    checks++; if ({consume, consume_count} !== 2'b11) begin failures++; $display("FAIL dest_zero_consume got=%b exp=11", {consume, consume_count}); end
    step(); clr(); exp_cnt += 2;
    checks++; if ({rf_we[1], rf_we[0]} !== 2'b00) begin failures++; $display("FAIL dest_zero_we got=%b exp=00", {rf_we[1], rf_we[0]}); end
    checks++; if (retired_count !== exp_retired()) begin failures++; $display("FAIL dest_zero_count got=%0d exp=%0d", retired_count, exp_retired()); end
  endtask

  task automatic test_empty();
    clr(); alu(0, 5'd9, 32'h9); alu(1, 5'd10, 32'hA); empty = 1'b1;
    settle();
    checks++; if (consume !== 1'b0) begin failures++; $display("FAIL empty_consume got=%0b exp=0", consume); end
    step(); clr();
    checks++; if ({rf_we[1], rf_we[0]} !== 2'b00) begin failures++; $display("FAIL empty_we got=%b exp=00", {rf_we[1], rf_we[0]}); end
  endtask

  task automatic test_store();
    clr(); store(0, 32'h100, 32'hCAFE); alu(1, 5'd11, 32'hB);
    settle();
    checks++; if (consume !== 1'b0) begin failures++; $display("FAIL store_detect_consume got=%0b exp=0", consume); end
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (st_req !== 1'b1 || st_addr !== 32'h100 || st_data !== 32'hCAFE) begin failures++; $display("FAIL store_hold_%0d got=%0b/%0h/%0h exp=1/100/cafe", i, st_req, st_addr, st_data); end
      slot_data[0].store_addr = 32'hDEAD;
      slot_data[0].store_data = 32'hBEEF;
      settle();
      checks++; if (consume !== 1'b0) begin failures++; $display("FAIL store_wait_consume_%0d got=%0b exp=0", i, consume); end
      step();
    end
    st_ack = 1'b1;
    settle();
    checks++; if ({st_req, consume, consume_count} !== 3'b110) begin failures++; $display("FAIL store_ack got=%b exp=110", {st_req, consume, consume_count}); end
    step(); clr(); exp_cnt += 1;
    checks++; if (st_req !== 1'b0 || {rf_we[1], rf_we[0]} !== 2'b00) begin failures++; $display("FAIL store_done got=%0b/%b exp=0/00", st_req, {rf_we[1], rf_we[0]}); end
    checks++; if (retired_count !== exp_retired()) begin failures++; $display("FAIL store_count got=%0d exp=%0d", retired_count, exp_retired()); end
    st_ack = 1'b1;
    settle();
    checks++; if (consume !== 1'b0) begin failures++; $display("FAIL stray_ack_consume got=%0b exp=0", consume); end
    step(); st_ack = 1'b0;
    checks++; if (st_req !== 1'b0) begin failures++; $display("FAIL stray_ack_req got=%0b exp=0", st_req); end
  endtask

  task automatic test_store_slot1();
    clr(); alu(0, 5'd9, 32'h99); store(1, 32'h180, 32'h5);
    settle();
    checks++; if ({consume, consume_count} !== 2'b10) begin failures++; $display("FAIL store_slot1_consume got=%b exp=10", {consume, consume_count}); end
    step(); clr(); exp_cnt += 1;
    checks++; if ({rf_we[1], rf_we[0]} !== 2'b01 || st_req !== 1'b0) begin failures++; $display("FAIL store_slot1_out got=%b/%0b exp=01/0", {rf_we[1], rf_we[0]}, st_req); end
  endtask

  task automatic test_exception();
    clr(); alu(0, 5'd2, 32'h55);
    slot_valid[1] = 1'b1; slot_data[1] = '0; slot_data[1].exception = 1'b1; slot_data[1].pc = 32'h40;
    settle();
    checks++; if ({consume, consume_count} !== 2'b10) begin failures++; $display("FAIL exc_prefix_consume got=%b exp=10", {consume, consume_count}); end
    step(); exp_cnt += 1;
    // ROB has advanced: the fault is now at the head, also flagged as a store.
    clr(); store(0, 32'h200, 32'h1); slot_data[0].exception = 1'b1; slot_data[0].pc = 32'h40;
    slot_data[0].dest_reg = 5'd12; slot_data[0].dest_reg_valid = 1'b1;
    checks++; if ({rf_we[1], rf_we[0]} !== 2'b01 || rf_waddr[0] !== 5'd2) begin failures++; $display("FAIL exc_prefix_we got=%b/%0d exp=01/2", {rf_we[1], rf_we[0]}, rf_waddr[0]); end
    settle();
    checks++; if ({consume, consume_count} !== 2'b10) begin failures++; $display("FAIL exc_head_consume got=%b exp=10", {consume, consume_count}); end
    step();
    clr(); alu(0, 5'd6, 32'h66);
    checks++; if (flush !== 1'b1 || flush_pc !== 32'h40) begin failures++; $display("FAIL flush_out got=%0b/%0h exp=1/40", flush, flush_pc); end
    checks++; if (st_req !== 1'b0 || {rf_we[1], rf_we[0]} !== 2'b00) begin failures++; $display("FAIL flush_side got=%0b/%b exp=0/00", st_req, {rf_we[1], rf_we[0]}); end
    settle();
    checks++; if (consume !== 1'b0) begin failures++; $display("FAIL flush_consume got=%0b exp=0", consume); end
    step();
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL flush_one_cycle got=%0b exp=0", flush); end
    settle();
    checks++; if ({consume, consume_count} !== 2'b10) begin failures++; $display("FAIL after_flush_consume got=%b exp=10", {consume, consume_count}); end
    step(); clr(); exp_cnt += 1;
    checks++; if ({rf_we[1], rf_we[0]} !== 2'b01 || rf_waddr[0] !== 5'd6) begin failures++; $display("FAIL after_flush_we got=%b/%0d exp=01/6", {rf_we[1], rf_we[0]}, rf_waddr[0]); end
    checks++; if (retired_count !== exp_retired()) begin failures++; $display("FAIL exc_count got=%0d exp=%0d", retired_count, exp_retired()); end
  endtask

  task automatic test_reset_in_wait();
    clr(); store(0, 32'h300, 32'h77);
    settle(); step();
    checks++; if (st_req !== 1'b1) begin failures++; $display("FAIL rwait_req_before got=%0b exp=1", st_req); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (st_req !== 1'b0 || consume !== 1'b0) begin failures++; $display("FAIL rwait_async got=%0b/%0b exp=0/0", st_req, consume); end
    st_ack = 1'b1;
    step(); step();
    exp_cnt = 0;
    reset_n = 1'b1;
    clr(); st_ack = 1'b1;
    settle();
    checks++; if (consume !== 1'b0) begin failures++; $display("FAIL rwait_late_ack got=%0b exp=0", consume); end
    checks++; if (retired_count !== 32'd0) begin failures++; $display("FAIL rwait_count got=%0d exp=0", retired_count); end
    step();
    clr(); alu(0, 5'd13, 32'hD);
    settle();
    checks++; if ({consume, consume_count, st_req} !== 3'b100) begin failures++; $display("FAIL rwait_run got=%b exp=100", {consume, consume_count, st_req}); end
    step(); clr(); exp_cnt += 1;
    checks++; if (retired_count !== exp_retired()) begin failures++; $display("FAIL rwait_count_after got=%0d exp=%0d", retired_count, exp_retired()); end
  endtask

  initial begin
    clr();
    test_reset();
    test_two_alu();
    test_partial();
    test_same_dest();
    test_dest_zero();
    test_empty();
    test_store();
    test_store_slot1();
    test_exception();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
